// File: rtl/minute_hour_counter.sv
// minute_hour_counter
//   Minutes/hours stage of a wall clock. It sits behind a seconds counter
//   that shares clk, which has one rising edge per second. Minutes advance
//   on the edge where the seconds stage wraps 59 -> 0. Hours advance when
//   the minutes wrap. Minutes and hours can be loaded directly.
//
// Ports
//   clk        system clock, one rising edge per second
//   clear_n    asynchronous active-low reset
//   sec_in     current seconds value from the upstream stage (0..59)
//   load       synchronous load strobe
//   load_sel   load target: 0 = minutes, 1 = hours
//   data       load value
//   mode12     display format: 0 = 24-hour, 1 = 12-hour
//   enable     databus output enable
//   rd_sel     databus source: 0 = minutes, 1 = display hour
//   min        minute count, 0..MIN_MAX
//   hour       hour count in 24-hour form, 0..HOUR_MAX
//   hour_disp  hour in the format selected by mode12
//   pm         high when hour >= 12
//   day_tick   one-cycle registered pulse after a counted HOUR_MAX -> 0 wrap
//   databus    gated read-back bus
module minute_hour_counter #(
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [5:0] sec_in,
    input  logic       load,
    input  logic       load_sel,
    input  logic [5:0] data,
    input  logic       mode12,
    input  logic       enable,
    input  logic       rd_sel,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] hour_disp,
    output logic       pm,
    output logic       day_tick,
    output logic [5:0] databus
);

    logic       min_carry;
    logic       min_wrap;
    logic       hour_carry;
    logic       hour_wrap;
    logic       min_load;
    logic       hour_load;
    logic [5:0] min_load_val;
    logic [4:0] hour_load_val;

    // The seconds stage wraps to 0 on the same edge that samples sec_in == 59.
    // Out-of-range seconds values never match, so they never carry.
    assign min_carry = (sec_in == 6'd59);
    assign min_wrap  = min_carry && (min == 6'(MIN_MAX));

    assign min_load  = load && !load_sel;
    assign hour_load = load && load_sel;

    // A minute load suppresses the carry. An hour load overwrites the hour,
    // so the carry is discarded. Either way, a load blocks the hour carry.
    assign hour_carry = min_wrap && !load;
    assign hour_wrap  = hour_carry && (hour == 5'(HOUR_MAX));

    // Out-of-range load values store 0. Hours take data[4:0] only.
    assign min_load_val  = (data > 6'(MIN_MAX)) ? 6'd0 : data;
    assign hour_load_val = (data[4:0] > 5'(HOUR_MAX)) ? 5'd0 : data[4:0];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            min      <= 6'd0;
            hour     <= 5'd0;
            day_tick <= 1'b0;
        end else begin
            if (min_load) begin
                min <= min_load_val;
            end else if (min_carry) begin
                min <= min_wrap ? 6'd0 : min + 6'd1;
            end

            if (hour_load) begin
                hour <= hour_load_val;
            end else if (hour_carry) begin
                hour <= hour_wrap ? 5'd0 : hour + 5'd1;
            end

            day_tick <= hour_wrap;
        end
    end

    assign pm = (hour >= 5'd12);

    // In 12-hour form, hour 0 is shown as 12. Hours 13..23 are shown as 1..11.
    always_comb begin
        hour_disp = hour;
        if (mode12) begin
            if (hour == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour > 5'd12) begin
                hour_disp = hour - 5'd12;
            end
        end
    end

    always_comb begin
        databus = 6'd0;
        if (enable) begin
            databus = rd_sel ? {1'b0, hour_disp} : min;
        end
    end

endmodule

// File: tb/tb_minute_hour_counter.sv
// Directed bench for minute_hour_counter.
// Inputs are driven, and outputs are sampled, on the falling clock edge.
module tb_minute_hour_counter;

    logic       clk;
    logic       clear_n;
    logic [5:0] sec_in;
    logic       load;
    logic       load_sel;
    logic [5:0] data;
    logic       mode12;
    logic       enable;
    logic       rd_sel;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       day_tick;
    logic [5:0] databus;

    int total = 0;
    int bad   = 0;

    minute_hour_counter #(.HOUR_MAX(23), .MIN_MAX(59)) dut (
        .clk(clk), .clear_n(clear_n), .sec_in(sec_in), .load(load),
        .load_sel(load_sel), .data(data), .mode12(mode12), .enable(enable),
        .rd_sel(rd_sel), .min(min), .hour(hour), .hour_disp(hour_disp),
        .pm(pm), .day_tick(day_tick), .databus(databus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then back at the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_load(input logic sel, input logic [5:0] val);
        sec_in = 6'd0; load = 1'b1; load_sel = sel; data = val;
        step();
        load = 1'b0;
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m);
        do_load(1'b1, {1'b0, h});
        do_load(1'b0, m);
    endtask

    task automatic test_reset();
        total++; if (min !== 6'd0) begin bad++; $display("FAIL reset_min got=%0d exp=0", min); end
        total++; if (hour !== 5'd0) begin bad++; $display("FAIL reset_hour got=%0d exp=0", hour); end
        total++; if (day_tick !== 1'b0) begin bad++; $display("FAIL reset_day_tick got=%b exp=0", day_tick); end
        total++; if (pm !== 1'b0) begin bad++; $display("FAIL reset_pm got=%b exp=0", pm); end
        total++; if (hour_disp !== 5'd0) begin bad++; $display("FAIL reset_disp24 got=%0d exp=0", hour_disp); end
        mode12 = 1'b1; #1;
        total++; if (hour_disp !== 5'd12) begin bad++; $display("FAIL reset_disp12 got=%0d exp=12", hour_disp); end
        mode12 = 1'b0;
        step();
        clear_n = 1'b1;
        step();
    endtask

    task automatic test_min_count();
        set_time(5'd5, 6'd58);
        sec_in = 6'd59;
        step();
        total++; if (min !== 6'd59 || hour !== 5'd5) begin bad++; $display("FAIL count_58 got=%0d:%0d exp=5:59", hour, min); end
        step();
        total++; if (min !== 6'd0 || hour !== 5'd6) begin bad++; $display("FAIL count_wrap got=%0d:%0d exp=6:0", hour, min); end
        total++; if (day_tick !== 1'b0) begin bad++; $display("FAIL count_no_tick got=%b exp=0", day_tick); end
        sec_in = 6'd0;
        step();
        total++; if (min !== 6'd0) begin bad++; $display("FAIL count_hold got=%0d exp=0", min); end
    endtask

    task automatic test_day_rollover();
        set_time(5'd23, 6'd59);
        sec_in = 6'd59;
        step();
        total++; if (min !== 6'd0 || hour !== 5'd0) begin bad++; $display("FAIL day_wrap got=%0d:%0d exp=0:0", hour, min); end
        total++; if (day_tick !== 1'b1) begin bad++; $display("FAIL day_tick_high got=%b exp=1", day_tick); end
        sec_in = 6'd0;
        step();
        total++; if (day_tick !== 1'b0) begin bad++; $display("FAIL day_tick_low got=%b exp=0", day_tick); end
    endtask

    task automatic test_load();
        // minute load suppresses the carry
        set_time(5'd10, 6'd59);
        sec_in = 6'd59; load = 1'b1; load_sel = 1'b0; data = 6'd59;
        step();
        load = 1'b0;
        total++; if (min !== 6'd59 || hour !== 5'd10) begin bad++; $display("FAIL minload_carry got=%0d:%0d exp=10:59", hour, min); end
        // hour load while minutes wrap: carry discarded
        sec_in = 6'd59; load = 1'b1; load_sel = 1'b1; data = 6'd3;
        step();
        load = 1'b0;
        total++; if (min !== 6'd0 || hour !== 5'd3) begin bad++; $display("FAIL hourload_carry got=%0d:%0d exp=3:0", hour, min); end
        // hour load at 23:59 with carry: no day_tick
        set_time(5'd23, 6'd59);
        sec_in = 6'd59; load = 1'b1; load_sel = 1'b1; data = 6'd23;
        step();
        load = 1'b0;
        total++; if (hour !== 5'd23 || min !== 6'd0) begin bad++; $display("FAIL load_23 got=%0d:%0d exp=23:0", hour, min); end
        total++; if (day_tick !== 1'b0) begin bad++; $display("FAIL load_no_tick got=%b exp=0", day_tick); end
        do_load(1'b1, 6'd30);
        total++; if (hour !== 5'd0) begin bad++; $display("FAIL hour_load_30 got=%0d exp=0", hour); end
        do_load(1'b1, 6'd14);
        total++; if (hour !== 5'd14) begin bad++; $display("FAIL hour_load_14 got=%0d exp=14", hour); end
        do_load(1'b1, 6'd37);  // data[4:0] = 5
        total++; if (hour !== 5'd5) begin bad++; $display("FAIL hour_load_bit5 got=%0d exp=5", hour); end
        do_load(1'b1, 6'd56);  // data[4:0] = 24, out of range
        total++; if (hour !== 5'd0) begin bad++; $display("FAIL hour_load_56 got=%0d exp=0", hour); end
        do_load(1'b0, 6'd60);
        total++; if (min !== 6'd0) begin bad++; $display("FAIL min_load_60 got=%0d exp=0", min); end
        do_load(1'b0, 6'd42);
        total++; if (min !== 6'd42) begin bad++; $display("FAIL min_load_42 got=%0d exp=42", min); end
    endtask

    task automatic test_display();
        logic [4:0] hrs  [6] = '{5'd0, 5'd1, 5'd11, 5'd12, 5'd13, 5'd23};
        logic [4:0] d12  [6] = '{5'd12, 5'd1, 5'd11, 5'd12, 5'd1, 5'd11};
        logic       pms  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            do_load(1'b1, {1'b0, hrs[i]});
            mode12 = 1'b1; #1;
            total++; if (hour_disp !== d12[i] || pm !== pms[i]) begin
                bad++; $display("FAIL disp12_h%0d got=%0d/%b exp=%0d/%b", hrs[i], hour_disp, pm, d12[i], pms[i]);
            end
            mode12 = 1'b0; #1;
            total++; if (hour_disp !== hrs[i]) begin bad++; $display("FAIL disp24_h%0d got=%0d exp=%0d", hrs[i], hour_disp, hrs[i]); end
        end
        set_time(5'd14, 6'd33);
        mode12 = 1'b1; enable = 1'b1; rd_sel = 1'b1; #1;
        total++; if (databus !== 6'd2 || pm !== 1'b1) begin bad++; $display("FAIL bus_h14 got=%0d/%b exp=2/1", databus, pm); end
        total++; if (hour !== 5'd14) begin bad++; $display("FAIL mode_keeps_hour got=%0d exp=14", hour); end
        rd_sel = 1'b0; #1;
        total++; if (databus !== 6'd33) begin bad++; $display("FAIL bus_min got=%0d exp=33", databus); end
        mode12 = 1'b0; rd_sel = 1'b1; #1;
        total++; if (databus !== 6'd14) begin bad++; $display("FAIL bus_h24 got=%0d exp=14", databus); end
        enable = 1'b0; #1;
        total++; if (databus !== 6'd0) begin bad++; $display("FAIL bus_disabled got=%0d exp=0", databus); end
        step();
    endtask

    task automatic test_bad_seconds();
        set_time(5'd7, 6'd5);
        sec_in = 6'd63;
        step();
        total++; if (min !== 6'd5) begin bad++; $display("FAIL sec63 got=%0d exp=5", min); end
        sec_in = 6'd60;
        step();
        total++; if (min !== 6'd5) begin bad++; $display("FAIL sec60 got=%0d exp=5", min); end
        sec_in = 6'd58;
        step();
        total++; if (min !== 6'd5) begin bad++; $display("FAIL sec58 got=%0d exp=5", min); end
        sec_in = 6'd0;
    endtask

    task automatic test_async_clear();
        set_time(5'd9, 6'd37);
        #2 clear_n = 1'b0;
        #1;
        total++; if (min !== 6'd0 || hour !== 5'd0) begin bad++; $display("FAIL async_clear got=%0d:%0d exp=0:0", hour, min); end
        step();
        // release between edges, with a carry on the first edge
        sec_in = 6'd59; clear_n = 1'b1;
        step();
        total++; if (min !== 6'd1 || hour !== 5'd0) begin bad++; $display("FAIL resume got=%0d:%0d exp=0:1", hour, min); end
        // pending day_tick dropped by reset
        set_time(5'd23, 6'd59);
        sec_in = 6'd59;
        step();
        sec_in = 6'd0;
        total++; if (day_tick !== 1'b1) begin bad++; $display("FAIL tick_before_clear got=%b exp=1", day_tick); end
        #2 clear_n = 1'b0;
        #1;
        total++; if (day_tick !== 1'b0) begin bad++; $display("FAIL tick_cleared got=%b exp=0", day_tick); end
        step();
        clear_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        // five consecutive carries from 22:57
        set_time(5'd22, 6'd57);
        sec_in = 6'd59;
        for (int i = 0; i < 5; i++) step();
        sec_in = 6'd0;
        total++; if (hour !== 5'd23 || min !== 6'd2) begin bad++; $display("FAIL b2b got=%0d:%0d exp=23:2", hour, min); end
    endtask

    initial begin
        clear_n = 1'b0; sec_in = 6'd0; load = 1'b0; load_sel = 1'b0;
        data = 6'd0; mode12 = 1'b0; enable = 1'b0; rd_sel = 1'b0;
        #2;
        test_reset();
        test_min_count();
        test_day_rollover();
        test_load();
        test_display();
        test_bad_seconds();
        test_async_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/minute_hour_counter.md
MINUTE_HOUR_COUNTER -- requirements
Module: minute_hour_counter

Interface
REQ-001 Parameter HOUR_MAX, default 23: highest hour value before wrap to 0.
REQ-002 Parameter MIN_MAX, default 59: highest minute value before wrap to 0.
REQ-003 clk  input  1  system clock; one rising edge per second, shared with the upstream seconds stage.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 sec_in  input  6  current seconds value from the upstream seconds counter (0..59).
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_sel  input  1  load target: 0 = minutes, 1 = hours.
REQ-008 data  input  6  load value.
REQ-009 mode12  input  1  display format: 0 = 24-hour, 1 = 12-hour.
REQ-010 enable  input  1  databus output enable.
REQ-011 rd_sel  input  1  databus source: 0 = minutes, 1 = display hour.
REQ-012 min  output  6  minute count, 0..MIN_MAX.
REQ-013 hour  output  5  hour count in 24-hour form, 0..HOUR_MAX.
REQ-014 hour_disp  output  5  hour in the format selected by mode12.
REQ-015 pm  output  1  high when hour >= 12.
REQ-016 day_tick  output  1  one-cycle pulse on the day rollover.
REQ-017 databus  output  6  gated read-back bus.

Function
REQ-018 Define the minute carry as sec_in == 59; it is sampled at the same edge on which the seconds stage wraps to 0.
REQ-019 On each rising edge with minute carry and no load, min SHALL increment by 1; when min == MIN_MAX it SHALL wrap to 0 and raise the hour carry.
REQ-020 On an hour carry with no hour load, hour SHALL increment by 1; when hour == HOUR_MAX it SHALL wrap to 0.
REQ-021 load=1 with load_sel=0 SHALL set min = data at the edge and suppress the hour carry on that edge; hour SHALL hold.
REQ-022 load=1 with load_sel=1 SHALL set hour = data[4:0] at the edge; minutes SHALL count normally on that edge, and any hour carry SHALL be discarded.
REQ-023 Load values above MIN_MAX (minutes) or above HOUR_MAX (hours) SHALL store 0; data[5] SHALL be ignored for hours, after the range check on data[4:0].
REQ-024 Load SHALL take priority over counting; both actions take effect on the same edge, with no added latency.
REQ-025 day_tick SHALL be registered and high for exactly the one cycle after the edge on which hour wraps HOUR_MAX->0 by counting; a load SHALL NOT generate day_tick.
REQ-026 pm SHALL be combinational: hour >= 12.
REQ-027 hour_disp SHALL equal hour when mode12=0.
REQ-028 When mode12=1, hour_disp SHALL be 12 for hour 0, hour for hours 1..12, and hour-12 for hours 13..23.
REQ-029 databus SHALL be combinational: 0 when enable=0; otherwise {0,min} for rd_sel=0, and {1'b0,hour_disp} for rd_sel=1.
REQ-030 Changing mode12 SHALL affect only hour_disp, pm and databus, never the stored hour.
REQ-031 sec_in values above 59 SHALL NOT generate a carry.

Reset
REQ-032 clear_n low SHALL immediately force min=0, hour=0 and day_tick=0, independent of clk.
REQ-033 With hour=0 during reset, hour_disp SHALL be 0 (mode12=0) or 12 (mode12=1), and pm=0.
REQ-034 Counting SHALL resume on the first rising edge after clear_n rises; loads and carries present on that edge SHALL be honoured.
REQ-035 Reset asserted mid-count SHALL discard any pending day_tick.

Verification
REQ-036 min=58, hour=5, sec_in=59, one edge -> min=59, hour=5; next carry edge -> min=0, hour=6, day_tick stays 0.
REQ-037 hour=23, min=59, sec_in=59, one edge -> hour=0, min=0; day_tick=1 for exactly one cycle, then 0.
REQ-038 load=1, load_sel=0, data=59 while sec_in=59 and min=59, hour=10 -> min=59, hour=10.
REQ-039 load=1, load_sel=1, data=30 -> hour=0.
REQ-040 load=1, load_sel=1, data=14 -> hour=14.
REQ-041 With hour=14: mode12=1, enable=1, rd_sel=1 -> databus=2, pm=1.
REQ-042 With hour=14: enable=0 -> databus=0.
REQ-043 Drive clear_n low between clock edges with min=37, hour=9 -> min=0, hour=0 immediately.
REQ-044 After clear_n rises, with sec_in=59 -> min=1 at the first edge.
